// File: rtl/config_pkg.sv
// Shared word and index types for the vector buffer slice.
package config_pkg;
   localparam int D    = 8;
   localparam int DI_W = $clog2(D);

   typedef logic [DI_W-1:0]    DI_t;
   typedef logic signed [15:0] fixed_point_t;
endpackage

// File: rtl/vector_buffer_ctrl_if.sv
// Stream-in, functional-unit and stream-out signals of the vector buffer.
interface vector_buffer_ctrl_if;
   import config_pkg::*;

   logic         in_valid_i;
   logic         in_ready_o;
   fixed_point_t in_data_i;
   logic         fu_valid_o;
   logic         fu_ready_i;
   logic         fu_w_en_i;
   DI_t          fu_w_addr_i;
   fixed_point_t fu_w_data_i;
   DI_t          fu_r_addr_i;
   fixed_point_t fu_r_data_o;
   logic         out_valid_o;
   logic         out_ready_i;
   fixed_point_t out_data_o;
   logic         out_last_o;

   modport slave (
      input  in_valid_i, in_data_i, fu_ready_i, fu_w_en_i, fu_w_addr_i,
             fu_w_data_i, fu_r_addr_i, out_ready_i,
      output in_ready_o, fu_valid_o, fu_r_data_o, out_valid_o, out_data_o, out_last_o
   );

   modport master (
      output in_valid_i, in_data_i, fu_ready_i, fu_w_en_i, fu_w_addr_i,
             fu_w_data_i, fu_r_addr_i, out_ready_i,
      input  in_ready_o, fu_valid_o, fu_r_data_o, out_valid_o, out_data_o, out_last_o
   );
endinterface

// File: rtl/vector_buffer_ctrl_mem.sv
// Vector storage: one synchronous write port, two asynchronous read ports (FU and drain).
module vector_mem
   import config_pkg::*;
(
   input  logic         clk_i,
   input  logic         i_we,
   input  DI_t          i_w_addr,
   input  fixed_point_t i_w_data,
   input  DI_t          i_r_addr,
   output fixed_point_t o_r_data,
   input  DI_t          i_d_addr,
   output fixed_point_t o_d_data
);
   // No reset: contents survive an aborted vector.
   fixed_point_t r_mem [D];

   always_ff @(posedge clk_i) begin
      if (i_we) r_mem[i_w_addr] <= i_w_data;
   end

   assign o_r_data = r_mem[i_r_addr];
   assign o_d_data = r_mem[i_d_addr];
endmodule

// File: rtl/vector_buffer_ctrl.sv
// Vector buffer sequencer: load a vector, hand it to the FU, drain the result.
// Optional RUN watchdog built when VECBUF_WATCHDOG_EN is defined.
//
// state      | meaning
// S_LOAD     | accepting input words into mem[cnt]
// S_DISPATCH | fu_valid_o high, waiting for fu_ready_i
// S_RUN      | FU owns the write port; fu_ready_i marks completion
// S_DRAIN    | streaming mem[cnt] out with backpressure
module vector_buffer_ctrl
   import config_pkg::*;
#(
   parameter int D               = config_pkg::D,
   parameter int WATCHDOG_CYCLES = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   vector_buffer_ctrl_if.slave  bus,
   output logic                 busy_o,
   output logic                 error_o
);
   localparam int CW = $clog2(D) + 1;
   localparam int AW = $clog2(D);

   typedef enum logic [1:0] {S_LOAD, S_DISPATCH, S_RUN, S_DRAIN} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_in_ready;
   logic            r_fu_valid;
   logic            r_out_valid;
   logic            r_out_last;

   logic            w_we;
   DI_t             w_w_addr;
   fixed_point_t    w_w_data;
   fixed_point_t    w_d_data;
   logic            w_cnt_last;

   assign w_cnt_last = (r_cnt == CW'(D - 1));

   always_comb begin
      w_we     = 1'b0;
      w_w_addr = r_cnt[AW-1:0];
      w_w_data = bus.in_data_i;
      if (r_state == S_LOAD) begin
         w_we = bus.in_valid_i;
      end else if (r_state == S_RUN) begin
         w_we     = bus.fu_w_en_i;
         w_w_addr = bus.fu_w_addr_i;
         w_w_data = bus.fu_w_data_i;
      end
   end

   vector_mem u_mem (
      .clk_i    (clk_i),
      .i_we     (w_we),
      .i_w_addr (w_w_addr),
      .i_w_data (w_w_data),
      .i_r_addr (bus.fu_r_addr_i),
      .o_r_data (bus.fu_r_data_o),
      .i_d_addr (r_cnt[AW-1:0]),
      .o_d_data (w_d_data)
   );

`ifdef VECBUF_WATCHDOG_EN
   localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
   logic [WW-1:0] r_wd;
   logic          r_error;
   assign error_o = r_error;
`else
   assign error_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_LOAD;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_fu_valid  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
`ifdef VECBUF_WATCHDOG_EN
         r_wd        <= '0;
         r_error     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_LOAD: begin
               if (bus.in_valid_i) begin
                  if (w_cnt_last) begin
                     r_state    <= S_DISPATCH;
                     r_cnt      <= '0;
                     r_in_ready <= 1'b0;
                     r_fu_valid <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_DISPATCH: begin
               if (bus.fu_ready_i) begin
                  r_state    <= S_RUN;
                  r_fu_valid <= 1'b0;
`ifdef VECBUF_WATCHDOG_EN
                  r_wd       <= WW'(WATCHDOG_CYCLES - 1);
`endif
               end
            end
            S_RUN: begin
               if (bus.fu_ready_i) begin
                  r_state     <= S_DRAIN;
                  r_out_valid <= 1'b1;
                  r_out_last  <= 1'b0;
               end
`ifdef VECBUF_WATCHDOG_EN
               // Down-counter terminal count: abort without draining.
               else if (r_wd == '0) begin
                  r_state    <= S_LOAD;
                  r_in_ready <= 1'b1;
                  r_error    <= 1'b1;
               end else begin
                  r_wd <= r_wd - 1'b1;
               end
`endif
            end
            S_DRAIN: begin
               if (bus.out_ready_i) begin
                  if (w_cnt_last) begin
                     r_state     <= S_LOAD;
                     r_cnt       <= '0;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_in_ready  <= 1'b1;
                  end else begin
                     r_cnt      <= r_cnt + 1'b1;
                     r_out_last <= (r_cnt == CW'(D - 2));
                  end
               end
            end
            default: begin
               r_state    <= S_LOAD;
               r_cnt      <= '0;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready_o  = r_in_ready;
   assign bus.fu_valid_o  = r_fu_valid;
   assign bus.out_valid_o = r_out_valid;
   assign bus.out_last_o  = r_out_last;
   assign bus.out_data_o  = r_out_valid ? w_d_data : '0;
   assign busy_o          = (r_state != S_LOAD);
endmodule

// File: tb/tb_vector_buffer_ctrl.sv
// Self-checking bench for vector_buffer_ctrl: table of vectors plus reset/watchdog sequences.
module tb_vector_buffer_ctrl;
   import config_pkg::*;

   typedef struct {
      fixed_point_t [D-1:0] words;
      int                   op;
      int                   k;
      int                   stall;
      int                   out_mode;
      bit                   cw;
      fixed_point_t         cw_val;
      fixed_point_t [D-1:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic busy, err;
   int   n_checks = 0;
   int   n_fail   = 0;

   vector_buffer_ctrl_if vif ();

   vector_buffer_ctrl #(.WATCHDOG_CYCLES(16)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .bus     (vif),
      .busy_o  (busy),
      .error_o (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // FU behaviour: 0 negate all, 1 add k, 2 untouched, 3 negate even words only.
   function automatic fixed_point_t fu_fn(int op, int k, int idx, fixed_point_t v);
      case (op)
         0:       return fixed_point_t'(-v);
         1:       return fixed_point_t'(v + k);
         3:       return (idx % 2 == 0) ? fixed_point_t'(-v) : v;
         default: return v;
      endcase
   endfunction

   function automatic bit fu_writes(int op, int idx);
      return (op == 0) || (op == 1) || (op == 3 && idx % 2 == 0);
   endfunction

   function automatic vec_t make_vec(bit seq, int op, int k, int stall, int mode,
                                     bit cw, fixed_point_t cwv);
      vec_t v;
      v.op = op; v.k = k; v.stall = stall; v.out_mode = mode; v.cw = cw; v.cw_val = cwv;
      for (int i = 0; i < D; i++) begin
         v.words[i] = seq ? fixed_point_t'(i) : fixed_point_t'($urandom);
         v.exp[i]   = fu_fn(op, k, i, v.words[i]);
      end
      if (cw) v.exp[2] = cwv;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_vector(input vec_t v, input int rst_at);
      int nfv, idx, cyc;
      bit ordy;
      // load
      for (int i = 0; i < D; i++) begin
         if (v.out_mode == 2 && $urandom_range(0, 1) == 1) begin
            vif.in_valid_i = 1'b0;
            tick();
         end
         check("load_in_ready", vif.in_ready_o, 1);
         vif.in_valid_i = 1'b1;
         vif.in_data_i  = v.words[i];
         tick();
      end
      vif.in_valid_i = 1'b0;
      check("dispatch_no_bubble", vif.fu_valid_o, 1);
      check("dispatch_in_ready", vif.in_ready_o, 0);
      check("dispatch_busy", busy, 1);
      // dispatch, with an FU write that must be ignored
      nfv = 0;
      vif.fu_ready_i = 1'b0;
      for (int s = 0; s < v.stall; s++) begin
         if (vif.fu_valid_o) nfv++;
         vif.fu_w_en_i   = 1'b1;
         vif.fu_w_addr_i = '0;
         vif.fu_w_data_i = 16'sh7777;
         tick();
      end
      vif.fu_w_en_i = 1'b0;
      if (vif.fu_valid_o) nfv++;
      vif.fu_ready_i = 1'b1;
      tick();
      check("fu_valid_cycles", nfv, v.stall + 1);
      check("run_fu_valid_low", vif.fu_valid_o, 0);
      vif.fu_ready_i = 1'b0;
      // FU stub
      for (int j = 0; j < D; j++) begin
         vif.fu_r_addr_i = DI_t'(j);
         #1;
         check("fu_read", vif.fu_r_data_o, v.words[j]);
         check("run_out_valid", vif.out_valid_o, 0);
         vif.fu_w_en_i   = fu_writes(v.op, j);
         vif.fu_w_addr_i = DI_t'(j);
         vif.fu_w_data_i = fu_fn(v.op, v.k, j, vif.fu_r_data_o);
         tick();
      end
      vif.fu_w_en_i   = v.cw;
      vif.fu_w_addr_i = DI_t'(2);
      vif.fu_w_data_i = v.cw_val;
      vif.fu_ready_i  = 1'b1;
      tick();
      vif.fu_w_en_i  = 1'b0;
      vif.fu_ready_i = 1'b0;
      // drain
      idx = 0; cyc = 0;
      while (idx < D && cyc < 4 * D + 8) begin
         if (idx == rst_at && vif.out_valid_o) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("rst_in_ready", vif.in_ready_o, 1);
            check("rst_out_valid", vif.out_valid_o, 0);
            check("rst_fu_valid", vif.fu_valid_o, 0);
            check("rst_busy", busy, 0);
            vif.fu_r_addr_i = DI_t'(5);
            #1;
            check("rst_mem_kept", vif.fu_r_data_o, v.exp[5]);
            return;
         end
         check("drain_valid", vif.out_valid_o, 1);
         check("drain_data", vif.out_data_o, v.exp[idx]);
         check("drain_last", vif.out_last_o, (idx == D - 1) ? 1 : 0);
         case (v.out_mode)
            0:       ordy = 1'b1;
            1:       ordy = (cyc % 2 == 0);
            default: ordy = 1'($urandom_range(0, 1));
         endcase
         vif.out_ready_i = ordy;
         tick();
         if (ordy) idx++;
         cyc++;
      end
      vif.out_ready_i = 1'b0;
      check("drain_count", idx, D);
      check("done_out_valid", vif.out_valid_o, 0);
      check("done_in_ready", vif.in_ready_o, 1);
      check("done_busy", busy, 0);
   endtask

   vec_t tbl [6];

   initial begin
      vif.in_valid_i = 1'b0; vif.in_data_i = '0;
      vif.fu_ready_i = 1'b0; vif.fu_w_en_i = 1'b0;
      vif.fu_w_addr_i = '0;  vif.fu_w_data_i = '0; vif.fu_r_addr_i = '0;
      vif.out_ready_i = 1'b0;
      rst = 1'b1;
      tbl[0] = make_vec(1'b1, 0, 0, 5, 0, 1'b0, '0);
      tbl[1] = make_vec(1'b1, 0, 0, 0, 1, 1'b0, '0);
      tbl[2] = make_vec(1'b0, 1, int'($urandom_range(1, 999)), 2, 2, 1'b1, 16'sh1234);
      tbl[3] = make_vec(1'b0, 2, 0, 1, 2, 1'b0, '0);
      tbl[4] = make_vec(1'b0, 3, 0, 0, 0, 1'b1, fixed_point_t'($urandom));
      tbl[5] = make_vec(1'b0, 0, 0, 3, 2, 1'b0, '0);

      tick(); tick();
      check("reset_in_ready", vif.in_ready_o, 1);
      check("reset_fu_valid", vif.fu_valid_o, 0);
      check("reset_out_valid", vif.out_valid_o, 0);
      check("reset_out_last", vif.out_last_o, 0);
      check("reset_out_data", vif.out_data_o, 0);
      check("reset_busy", busy, 0);
      check("reset_error", err, 0);
      rst = 1'b0;
      tick();

      for (int t = 0; t < 6; t++) run_vector(tbl[t], -1);

      run_vector(make_vec(1'b1, 0, 0, 0, 0, 1'b0, '0), 3);
      run_vector(tbl[0], -1);

      for (int r = 0; r < 10; r++)
         run_vector(make_vec(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 500)),
                             int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                             1'($urandom_range(0, 1)), fixed_point_t'($urandom)), -1);

      check("error_default", err, 0);

`ifdef VECBUF_WATCHDOG_EN
      for (int i = 0; i < D; i++) begin
         vif.in_valid_i = 1'b1;
         vif.in_data_i  = fixed_point_t'(i);
         tick();
      end
      vif.in_valid_i = 1'b0;
      vif.fu_ready_i = 1'b1;
      tick();
      vif.fu_ready_i = 1'b0;
      for (int c = 1; c < 16; c++) begin
         tick();
         check("wd_out_valid", vif.out_valid_o, 0);
         check("wd_error_early", err, 0);
      end
      check("wd_busy_before", busy, 1);
      tick();
      check("wd_error", err, 1);
      check("wd_in_ready", vif.in_ready_o, 1);
      check("wd_out_valid_after", vif.out_valid_o, 0);
      check("wd_busy_after", busy, 0);
      run_vector(tbl[1], -1);
      check("wd_error_sticky", err, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("wd_error_cleared", err, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
